// File: rtl/fir_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fir_rr_scheduler
//  Purpose  : Round-robin scheduler that shares one 3-tap decaying-weight FIR
//             datapath between NCH requesters. Each channel keeps its own tap
//             history. Results leave on a valid/ready port tagged with the
//             channel number.
//  Options  : FIR_SAT_EN defined   -> sums above 2^DW-1 saturate
//             FIR_SAT_EN undefined -> sums wrap modulo 2^DW
//  Revision : 1.0 - initial release
// ============================================================================
module fir_rr_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = $clog2(NCH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH-1:0]    ch_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_ch_q, out_ch_d;
    logic [DW-1:0]   h0_q [NCH];
    logic [DW-1:0]   h1_q [NCH];
    logic [DW-1:0]   h2_q [NCH];
    logic [DW-1:0]   h0_d [NCH];
    logic [DW-1:0]   h1_d [NCH];
    logic [DW-1:0]   h2_d [NCH];

    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic [CW:0]     cand;
    logic            accept;
    logic [DW-1:0]   sel_x, sel_h0, sel_h1, sel_h2;
    logic [DW+1:0]   sum;
    logic [DW-1:0]   result;

    // Round-robin search: first valid channel at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (!grant_found && req_valid[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CW-1:0];
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (RST && state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = RST && (state_q == S_IDLE) && grant_found;

    // Steer the granted channel's sample and history into the shared datapath.
    always_comb begin
        sel_x  = '0;
        sel_h0 = '0;
        sel_h1 = '0;
        sel_h2 = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant_idx == CW'(c)) begin
                sel_x  = req_data[c*DW +: DW];
                sel_h0 = h0_q[c];
                sel_h1 = h1_q[c];
                sel_h2 = h2_q[c];
            end
        end
    end

    // Shared FIR: x + h0/2 + h1/4 + h2/8 at DW+2 bits, then reduced to DW.
    always_comb begin
        sum = (DW+2)'(sel_x) + (DW+2)'(sel_h0 >> 1)
            + (DW+2)'(sel_h1 >> 2) + (DW+2)'(sel_h2 >> 3);
`ifdef FIR_SAT_EN
        result = (sum > (DW+2)'({DW{1'b1}})) ? {DW{1'b1}} : DW'(sum);
`else
        result = DW'(sum);
`endif
    end

    // Per-channel history: shift on accept, clear on ch_clr (clear wins for
    // the older taps of the accepted channel, newest tap takes the sample).
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            h0_d[c] = h0_q[c];
            h1_d[c] = h1_q[c];
            h2_d[c] = h2_q[c];
            if (accept && grant_idx == CW'(c)) begin
                h0_d[c] = req_data[c*DW +: DW];
                h1_d[c] = ch_clr[c] ? '0 : h0_q[c];
                h2_d[c] = ch_clr[c] ? '0 : h1_q[c];
            end else if (ch_clr[c]) begin
                h0_d[c] = '0;
                h1_d[c] = '0;
                h2_d[c] = '0;
            end
        end
    end

    // Transaction control: capture result on accept, hold it until taken.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    out_data_d = result;
                    out_ch_d   = grant_idx;
                    ptr_d      = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer, output and history registers with async active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                h0_q[c] <= '0;
                h1_q[c] <= '0;
                h2_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            h2_q       <= h2_d;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_rr_scheduler
//  Purpose  : Self-checking bench for fir_rr_scheduler with a behavioural
//             reference model (per-channel tap arrays, round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_rr_scheduler;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int MAXV = (1 << DW) - 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*DW-1:0] req_data = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    ch_clr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_h [NCH][3];
    int m_ptr, m_out, m_out_data, m_out_ch, m_acc;

    fir_rr_scheduler #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ch_clr    (ch_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int xof(int c);
        return int'(req_data[c*DW +: DW]);
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_out = 0; m_out_data = 0; m_out_ch = 0; m_acc = -1;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 3; k++) m_h[c][k] = 0;
    endtask

    // Channel granted by the rules given the current inputs, or -1.
    function automatic int m_grant();
        if (RST !== 1'b1 || m_out != 0) return -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (req_valid[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_ready();
        logic [NCH-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic int m_result(int c, int x);
        int s;
        s = x + m_h[c][0] / 2 + m_h[c][1] / 4 + m_h[c][2] / 8;
`ifdef FIR_SAT_EN
        if (s > MAXV) s = MAXV;
`else
        s = s % (MAXV + 1);
`endif
        return s;
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        int g;
        int nh [NCH][3];
        m_acc = -1;
        if (RST !== 1'b1) begin
            m_reset();
            return;
        end
        g = m_grant();
        nh = m_h;
        if (g >= 0) begin
            m_out_data = m_result(g, xof(g));
            m_out_ch   = g;
            m_ptr      = (g + 1) % NCH;
            m_out      = 1;
            m_acc      = g;
        end else if (m_out != 0 && out_ready) begin
            m_out = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (c == g) begin
                nh[c][0] = xof(c);
                nh[c][1] = ch_clr[c] ? 0 : m_h[c][0];
                nh[c][2] = ch_clr[c] ? 0 : m_h[c][1];
            end else if (ch_clr[c]) begin
                nh[c][0] = 0; nh[c][1] = 0; nh[c][2] = 0;
            end
        end
        m_h = nh;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0; ch_clr = '0; out_ready = 1'b1;
        RST = 1'b0;
        m_reset();
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        int lo;
        RST = 1'b0;
        m_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'($urandom); req_data = 32'($urandom);
            ch_clr = 4'($urandom); out_ready = 1'($urandom);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
            total++; if (out_data !== 8'd0 || out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_data: got %0d ch %0d want 0 ch 0", out_data, out_ch); end
            tick();
        end
        ch_clr = '0; out_ready = 1'b0;
        req_valid = 4'($urandom) | 4'b1000;
        req_data = 32'($urandom);
        RST = 1'b1;
        lo = 0;
        for (int c = NCH - 1; c >= 0; c--) if (req_valid[c]) lo = c;
        #1;
        total++; if (req_ready !== 4'(1 << lo)) begin bad++; $display("FAIL release_grant: got %b want %b", req_ready, 4'(1 << lo)); end
        tick();
        total++; if (out_valid !== 1'b1 || int'(out_data) !== xof(lo) || int'(out_ch) !== lo) begin
            bad++; $display("FAIL release_first_result: got v=%b d=%0d ch=%0d want v=1 d=%0d ch=%0d", out_valid, out_data, out_ch, xof(lo), lo);
        end
        req_valid = '0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_single_channel();
        int exp_r [4] = '{8, 12, 14, 15};
        reset_dut();
        req_data[0 +: DW] = 8'd8;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            #1;
            total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant[%0d]: got %b want 0001", i, req_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || int'(out_data) !== exp_r[i] || out_ch !== 2'd0) begin
                bad++; $display("FAIL single_result[%0d]: got v=%b d=%0d ch=%0d want v=1 d=%0d ch=0", i, out_valid, out_data, out_ch, exp_r[i]);
            end
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_busy_ready[%0d]: got %b want 0000", i, req_ready); end
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_spacing[%0d]: out_valid got %b want 0", i, out_valid); end
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] w;
        reset_dut();
        req_data = {8'($urandom), 8'($urandom), 8'd16, 8'd8};
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            w = '0; w[k % NCH] = 1'b1;
            #1;
            total++; if (req_ready !== w) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, w); end
            tick();
            total++; if (int'(out_ch) !== k % NCH || int'(out_data) !== m_out_data) begin
                bad++; $display("FAIL rr_result[%0d]: got ch=%0d d=%0d want ch=%0d d=%0d", k, out_ch, out_data, k % NCH, m_out_data);
            end
            if (k == 4) begin
                total++; if (out_data !== 8'd12) begin bad++; $display("FAIL rr_ch0_round2: got %0d want 12", out_data); end
            end
            if (k == 5) begin
                total++; if (out_data !== 8'd24) begin bad++; $display("FAIL rr_ch1_round2: got %0d want 24", out_data); end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        int want;
`ifdef FIR_SAT_EN
        want = 255;
`else
        want = 220;
`endif
        reset_dut();
        req_data[2*DW +: DW] = 8'd255;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0100;
            #1;
            tick();
            total++; if (out_ch !== 2'd2 || int'(out_data) !== m_out_data) begin
                bad++; $display("FAIL sat_step[%0d]: got ch=%0d d=%0d want ch=2 d=%0d", i, out_ch, out_data, m_out_data);
            end
            if (i == 3) begin
                total++; if (int'(out_data) !== want) begin bad++; $display("FAIL sat_final: got %0d want %0d", out_data, want); end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hd;
        logic [CW-1:0] hc;
        reset_dut();
        req_data = 32'($urandom);
        req_valid = 4'b0011;
        out_ready = 1'b0;
        #1;
        tick();
        hd = out_data; hc = out_ch;
        total++; if (out_ch !== 2'd0 || int'(out_data) !== xof(0)) begin
            bad++; $display("FAIL bp_first: got ch=%0d d=%0d want ch=0 d=%0d", out_ch, out_data, xof(0));
        end
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== hd || out_ch !== hc || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d ch=%0d rdy=%b want v=1 d=%0d ch=%0d rdy=0000", i, out_valid, out_data, out_ch, req_ready, hd, hc);
            end
        end
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
        tick();
        total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL bp_next_ch: got %0d want 1", out_ch); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_clear_on_accept();
        reset_dut();
        req_data[DW +: DW] = 8'd8;
        req_data[3*DW +: DW] = 8'd40;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0010; #1; tick(); tick();
        end
        ch_clr = 4'b1010;
        req_valid = 4'b0010;
        #1;
        tick();
        ch_clr = '0;
        total++; if (out_data !== 8'd15 || out_ch !== 2'd1) begin bad++; $display("FAIL clr_result: got d=%0d ch=%0d want d=15 ch=1", out_data, out_ch); end
        tick();
        #1;
        tick();
        total++; if (out_data !== 8'd12) begin bad++; $display("FAIL clr_after: got %0d want 12", out_data); end
        tick();
        req_valid = 4'b1000;
        #1;
        tick();
        total++; if (out_data !== 8'd40 || out_ch !== 2'd3) begin bad++; $display("FAIL clr_other_channel: got d=%0d ch=%0d want d=40 ch=3", out_data, out_ch); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int wt [NCH];
        reset_dut();
        for (int c = 0; c < NCH; c++) wt[c] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!req_valid[c] && $urandom_range(0, 2) == 0) begin
                    req_valid[c] = 1'b1;
                    req_data[c*DW +: DW] = 8'($urandom);
                    wt[c] = 0;
                end
            end
            ch_clr    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
            if (n == 300) begin
                RST = 1'b0;
                #1;
                total++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
                    bad++; $display("FAIL rand_async_reset: got v=%b rdy=%b want v=0 rdy=0000", out_valid, req_ready);
                end
                m_reset();
            end
            if (n == 302) RST = 1'b1;
            #1;
            total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", n, req_ready, exp_ready()); end
            tick();
            total++; if (out_valid !== (m_out != 0)) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %0d", n, out_valid, m_out); end
            if (m_out != 0) begin
                total++; if (int'(out_data) !== m_out_data || int'(out_ch) !== m_out_ch) begin
                    bad++; $display("FAIL rand_result[%0d]: got d=%0d ch=%0d want d=%0d ch=%0d", n, out_data, out_ch, m_out_data, m_out_ch);
                end
            end
            if (m_acc >= 0) begin
                total++; if (wt[m_acc] > NCH) begin bad++; $display("FAIL rand_fairness[%0d]: ch %0d waited %0d want <= %0d", n, m_acc, wt[m_acc], NCH); end
                for (int c = 0; c < NCH; c++) if (c != m_acc && req_valid[c]) wt[c]++;
                req_valid[m_acc] = 1'b0;
            end
        end
        req_valid = '0; ch_clr = '0;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_clear_on_accept();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
